// File: rtl/nios_system_nios2_qsys_oci_dct_packer.sv
// nios_system_nios2_qsys_oci_dct_packer
// Packs 3-bit DCT trace codes into 30-bit words (up to ten codes), stages
// completed words on a valid/ready handshake and sequences end-of-test drain.
// Optional feature macro: OCI_DCT_DROP_CNT_EN enables the saturating
// drop_count register; without it drop_count is tied to zero.
module nios_system_nios2_qsys_oci_dct_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trc_on,
  input  logic        code_valid,
  input  logic [2:0]  code,
  input  logic        flush,
  input  logic        test_ending,
  input  logic        word_ready,
  output logic        word_valid,
  output logic [29:0] word_data,
  output logic [3:0]  word_count,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENDING = 2'd1,
    ST_ENDED  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic        fp_r;
  logic        fp_s;
  logic        eligible_s;
  logic        stage_free_s;
  logic        transfer_s;
  logic        accept_s;
  logic        drop_s;
  logic        enter_end_s;
  logic [29:0] buf_s;
  logic [3:0]  cnt_s;

  // Datapath decisions, packing-register next value and FSM next state.
  always_comb begin
    state_s      = state_r;
    enter_end_s  = 1'b0;
    buf_s        = dct_buffer;
    cnt_s        = dct_count;
    fp_s         = fp_r;
    eligible_s   = trc_on && code_valid && (code != 3'd0) && (state_r == ST_RUN);
    stage_free_s = !word_valid || word_ready;
    transfer_s   = ((dct_count == 4'd10) || (fp_r && (dct_count != 4'd0))) && stage_free_s;
    accept_s     = eligible_s && (dct_count < 4'd10) && !transfer_s;
    drop_s       = eligible_s && (dct_count == 4'd10) && !transfer_s;

    if (transfer_s) begin
      // A code arriving with the transfer starts the next word.
      if (eligible_s) begin
        buf_s = {27'd0, code};
        cnt_s = 4'd1;
      end else begin
        buf_s = 30'd0;
        cnt_s = 4'd0;
      end
    end else if (accept_s) begin
      buf_s = {dct_buffer[26:0], code};
      cnt_s = dct_count + 4'd1;
    end else begin
      buf_s = dct_buffer;
      cnt_s = dct_count;
    end

    case (state_r)
      ST_RUN: begin
        if (test_ending) begin
          state_s     = ST_ENDING;
          enter_end_s = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_ENDING: begin
        if ((dct_count == 4'd0) && !fp_r && stage_free_s && !transfer_s) begin
          state_s = ST_ENDED;
        end else begin
          state_s = ST_ENDING;
        end
      end
      ST_ENDED: state_s = ST_ENDED;
      default:  state_s = ST_RUN;
    endcase

    // A flush request only sticks when there is something left to emit;
    // otherwise a transfer satisfies and clears any pending flush.
    if (flush || enter_end_s) begin
      fp_s = (cnt_s != 4'd0);
    end else if (transfer_s) begin
      fp_s = 1'b0;
    end else begin
      fp_s = fp_r;
    end
  end

  // FSM state, flush-pending flag and packing register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_RUN;
      fp_r       <= 1'b0;
      dct_buffer <= 30'd0;
      dct_count  <= 4'd0;
    end else begin
      state_r    <= state_s;
      fp_r       <= fp_s;
      dct_buffer <= buf_s;
      dct_count  <= cnt_s;
    end
  end

  // Output stage: loads on transfer, empties when consumed, holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_valid <= 1'b0;
      word_data  <= 30'd0;
      word_count <= 4'd0;
    end else if (transfer_s) begin
      word_valid <= 1'b1;
      word_data  <= dct_buffer;
      word_count <= dct_count;
    end else if (word_ready) begin
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_valid;
    end
  end

  // Sticky overflow and end-of-test flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow       <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow <= 1'b1;
      end
      if (state_s == ST_ENDED) begin
        test_has_ended <= 1'b1;
      end
    end
  end

`ifdef OCI_DCT_DROP_CNT_EN
  // Saturating count of dropped codes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= 8'd0;
    end else if (drop_s && (drop_count != 8'd255)) begin
      drop_count <= drop_count + 8'd1;
    end else begin
      drop_count <= drop_count;
    end
  end
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_nios_system_nios2_qsys_oci_dct_packer.sv
// Self-checking bench for nios_system_nios2_qsys_oci_dct_packer: a queue-based
// reference model is stepped every cycle alongside directed and random stimulus.
module tb_nios_system_nios2_qsys_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trc_on;
  logic        code_valid;
  logic [2:0]  code;
  logic        flush;
  logic        test_ending;
  logic        word_ready;
  logic        word_valid;
  logic [29:0] word_data;
  logic [3:0]  word_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        test_has_ended;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int unsigned m_q[$];
  bit          m_wv;
  logic [31:0] m_wd;
  int unsigned m_wc;
  bit          m_fp;
  int unsigned m_phase;   // 0 run, 1 ending, 2 ended
  bit          m_ovf;
  int unsigned m_drops;

  nios_system_nios2_qsys_oci_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .trc_on(trc_on), .code_valid(code_valid),
    .code(code), .flush(flush), .test_ending(test_ending), .word_ready(word_ready),
    .word_valid(word_valid), .word_data(word_data), .word_count(word_count),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow),
    .drop_count(drop_count), .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pack(input int unsigned q[$]);
    logic [31:0] w;
    w = 32'd0;
    foreach (q[i]) w = w * 32'd8 + q[i];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q = {};
    m_wv = 1'b0; m_wd = 32'd0; m_wc = 0; m_fp = 1'b0;
    m_phase = 0; m_ovf = 1'b0; m_drops = 0;
  endtask

  // Applies the packing rules to the inputs currently driven.
  task automatic model_step();
    bit elig, free, xfer, req;
    int unsigned old_size;
    bit old_fp;
    old_size = m_q.size();
    old_fp   = m_fp;
    elig = trc_on && code_valid && (code != 3'd0) && (m_phase == 0);
    free = !m_wv || word_ready;
    xfer = ((old_size == 10) || (old_fp && old_size != 0)) && free;
    if (xfer) begin
      m_wd = pack(m_q); m_wc = old_size; m_wv = 1'b1;
      m_q = {};
      if (elig) m_q.push_back(int'(code));
    end else begin
      if (m_wv && word_ready) m_wv = 1'b0;
      if (elig) begin
        if (old_size < 10) m_q.push_back(int'(code));
        else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
    req = flush || (m_phase == 0 && test_ending);
    if (req) m_fp = (m_q.size() != 0);
    else if (xfer) m_fp = 1'b0;
    if (m_phase == 0 && test_ending) m_phase = 1;
    else if (m_phase == 1 && old_size == 0 && !old_fp && free && !xfer) m_phase = 2;
  endtask

  task automatic check_all();
    logic [31:0] exp_drops;
`ifdef OCI_DCT_DROP_CNT_EN
    exp_drops = m_drops;
`else
    exp_drops = 32'd0;
`endif
    chk("word_valid", {31'd0, word_valid}, {31'd0, m_wv});
    chk("word_count", {28'd0, word_count}, m_wc);
    if (m_wv) chk("word_data", {2'd0, word_data}, m_wd);
    chk("dct_buffer", {2'd0, dct_buffer}, pack(m_q));
    chk("dct_count", {28'd0, dct_count}, m_q.size());
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("drop_count", {24'd0, drop_count}, exp_drops);
    chk("test_has_ended", {31'd0, test_has_ended}, {31'd0, (m_phase == 2)});
  endtask

  task automatic cyc(input logic tv, input logic cv, input logic [2:0] c,
                     input logic fl, input logic te, input logic rdy);
    trc_on = tv; code_valid = cv; code = c; flush = fl; test_ending = te; word_ready = rdy;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_all();
  endtask

  logic [2:0] fw_codes [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3};

  initial begin
    reset_n = 1'b1; trc_on = 1'b0; code_valid = 1'b0; code = 3'd0;
    flush = 1'b0; test_ending = 1'b0; word_ready = 1'b0;
    #2;
    do_reset();

    // Full word
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, fw_codes[i], 1'b0, 1'b0, 1'b1);
    chk("full_cnt10", {28'd0, dct_count}, 32'd10);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("full_data", {2'd0, word_data}, 32'h0A72EE53);
    chk("full_count", {28'd0, word_count}, 32'd10);
    chk("full_empty", {28'd0, dct_count}, 32'd0);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Partial flush, then flush of an empty buffer
    cyc(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("flush_valid", {31'd0, word_valid}, 32'd1);
    chk("flush_data", {2'd0, word_data}, 32'h2B);
    chk("flush_count", {28'd0, word_count}, 32'd2);
    cyc(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("empty_flush", {31'd0, word_valid}, 32'd0);

    // Idle codes and trace disabled
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1);
    chk("idle_cnt", {28'd0, dct_count}, 32'd0);
    chk("idle_ovf", {31'd0, overflow}, 32'd0);

    // Backpressure and drop
    for (int i = 0; i < 21; i++) cyc(1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    chk("bp_valid", {31'd0, word_valid}, 32'd1);
    chk("bp_wcount", {28'd0, word_count}, 32'd10);
    chk("bp_dcount", {28'd0, dct_count}, 32'd10);
    chk("bp_ovf", {31'd0, overflow}, 32'd1);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("bp_second", {2'd0, word_data}, 32'h3FFFFFFF);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom_range(9) != 0), 1'($urandom), 3'($urandom),
          ($urandom_range(15) == 0), 1'b0, 1'($urandom));

    // End of test
    do_reset();
    cyc(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("end_data", {2'd0, word_data}, 32'h24);
    chk("end_count", {28'd0, word_count}, 32'd2);
    chk("end_not_yet", {31'd0, test_has_ended}, 32'd0);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
    chk("end_flag", {31'd0, test_has_ended}, 32'd1);
    chk("end_ignored", {28'd0, dct_count}, 32'd0);

    // Mid-word reset
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
    #2;
    do_reset();
    chk("rst_cnt", {28'd0, dct_count}, 32'd0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_word", {2'd0, word_data}, 32'h36DB6DB6);
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
